// File: rtl/rst_gen.sv
// Reset generator: synchronized, debounced button plus a software handshake drive
// three domain resets that are released in order 0, 1, 2 after a stretch period.
module rst_gen #(
  parameter int STRETCH_CYC = 16,
  parameter int SEQ_GAP     = 4,
  parameter int DEB_CYC     = 8
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic btn_rst_n_i,
  input  logic sw_rst_req_i,
  output logic sw_rst_ack_o,
  output logic rst0_n_o,
  output logic rst1_n_o,
  output logic rst2_n_o,
  output logic busy_o
);

  localparam logic [7:0] LP_STRETCH = 8'(STRETCH_CYC);
  localparam logic [7:0] LP_GAP     = 8'(SEQ_GAP);
  localparam logic [7:0] LP_DEB_M1  = 8'(DEB_CYC - 1);

  typedef enum logic [2:0] {
    ST_ASSERT = 3'd0,
    ST_REL0   = 3'd1,
    ST_REL1   = 3'd2,
    ST_REL2   = 3'd3,
    ST_RUN    = 3'd4
  } state_t;

  logic       r_sync1, r_sync2, r_deb;
  logic [7:0] r_deb_cnt;
  state_t     r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic       r_pend, w_pend_nxt, w_ack_nxt;
  logic       w_rst0, w_rst1, w_rst2, w_busy;
  logic       w_accept;

  // Debounced level flips only after DEB_CYC consecutive samples at the new level
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_deb     <= 1'b1;
      r_deb_cnt <= 8'd0;
    end else begin
      r_sync1 <= btn_rst_n_i;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_deb) begin
        if (r_deb_cnt >= LP_DEB_M1) begin
          r_deb     <= r_sync2;
          r_deb_cnt <= 8'd0;
        end else begin
          r_deb_cnt <= r_deb_cnt + 8'd1;
        end
      end else begin
        r_deb_cnt <= 8'd0;
      end
    end
  end

  assign w_accept = (r_state == ST_RUN) && sw_rst_req_i && !sw_rst_ack_o && !r_pend;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_ASSERT;
      r_cnt        <= LP_STRETCH;
      r_pend       <= 1'b0;
      sw_rst_ack_o <= 1'b0;
      rst0_n_o     <= 1'b0;
      rst1_n_o     <= 1'b0;
      rst2_n_o     <= 1'b0;
      busy_o       <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_pend       <= w_pend_nxt;
      sw_rst_ack_o <= w_ack_nxt;
      rst0_n_o     <= w_rst0;
      rst1_n_o     <= w_rst1;
      rst2_n_o     <= w_rst2;
      busy_o       <= w_busy;
    end
  end

  // A press or an accepted request always restarts from a full stretch
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (!r_deb || w_accept) begin
      w_state_nxt = ST_ASSERT;
      w_cnt_nxt   = LP_STRETCH;
    end else begin
      case (r_state)
        ST_ASSERT: begin
          if (r_cnt <= 8'd1) begin
            w_state_nxt = ST_REL0;
            w_cnt_nxt   = LP_GAP;
          end else begin
            w_cnt_nxt = r_cnt - 8'd1;
          end
        end
        ST_REL0: begin
          if (r_cnt <= 8'd1) begin
            w_state_nxt = ST_REL1;
            w_cnt_nxt   = LP_GAP;
          end else begin
            w_cnt_nxt = r_cnt - 8'd1;
          end
        end
        // rst2 release and RUN entry coincide, so REL1 expiry lands directly in RUN
        ST_REL1: begin
          if (r_cnt <= 8'd1) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_cnt_nxt = r_cnt - 8'd1;
          end
        end
        ST_REL2: w_state_nxt = ST_RUN;
        ST_RUN:  w_state_nxt = ST_RUN;
        default: begin
          w_state_nxt = ST_ASSERT;
          w_cnt_nxt   = LP_STRETCH;
        end
      endcase
    end
  end

  always_comb begin
    w_rst0     = (w_state_nxt != ST_ASSERT);
    w_rst1     = (w_state_nxt == ST_REL1) || (w_state_nxt == ST_REL2) || (w_state_nxt == ST_RUN);
    w_rst2     = (w_state_nxt == ST_RUN);
    w_busy     = (w_state_nxt != ST_RUN);
    w_pend_nxt = r_pend;
    w_ack_nxt  = sw_rst_ack_o;
    if (w_accept) begin
      w_pend_nxt = 1'b1;
    end
    // A request withdrawn before completion is forgotten once RUN is reached
    if ((r_state == ST_RUN) && r_pend && sw_rst_req_i) begin
      w_ack_nxt  = 1'b1;
      w_pend_nxt = 1'b0;
    end else if (((r_state == ST_RUN) || (w_state_nxt == ST_RUN)) && !sw_rst_req_i) begin
      w_pend_nxt = 1'b0;
    end
    if (sw_rst_ack_o && !sw_rst_req_i) begin
      w_ack_nxt = 1'b0;
    end
  end

endmodule

// File: tb/tb_rst_gen.sv
// Directed bench for rst_gen: a table of {btn, req, cycles, expected outputs}
// records plus a hand-written asynchronous reset sequence.
module tb_rst_gen;

  logic clk_i = 1'b0;
  logic rst_n;
  logic btn_rst_n_i;
  logic sw_rst_req_i;
  logic sw_rst_ack_o;
  logic rst0_n_o, rst1_n_o, rst2_n_o, busy_o;

  typedef struct {
    logic       btn;
    logic       req;
    int         ncyc;
    logic [4:0] exp;  // {rst0, rst1, rst2, busy, ack}
  } vec_t;

  vec_t vq[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   n_split;

  rst_gen #(.STRETCH_CYC(16), .SEQ_GAP(4), .DEB_CYC(8)) dut (
    .clk_i        (clk_i),
    .rst_n        (rst_n),
    .btn_rst_n_i  (btn_rst_n_i),
    .sw_rst_req_i (sw_rst_req_i),
    .sw_rst_ack_o (sw_rst_ack_o),
    .rst0_n_o     (rst0_n_o),
    .rst1_n_o     (rst1_n_o),
    .rst2_n_o     (rst2_n_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic add(input logic b, input logic r, input int n, input logic [4:0] e);
    vec_t v;
    v.btn = b; v.req = r; v.ncyc = n; v.exp = e;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [4:0] e);
    logic [4:0] got;
    got = {rst0_n_o, rst1_n_o, rst2_n_o, busy_o, sw_rst_ack_o};
    n_vec++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL %s: got {r0,r1,r2,busy,ack}=%b expected %b at %0t", name, got, e, $time);
    end
  endtask

  task automatic apply(input int i);
    btn_rst_n_i  = vq[i].btn;
    sw_rst_req_i = vq[i].req;
    repeat (vq[i].ncyc) @(posedge clk_i);
    @(negedge clk_i);
    check($sformatf("vec%0d", i), vq[i].exp);
  endtask

  initial begin
    // power-on timeline
    add(1, 0, 15, 5'b00010); add(1, 0, 1, 5'b10010); add(1, 0, 3, 5'b10010);
    add(1, 0, 1, 5'b11010);  add(1, 0, 3, 5'b11010); add(1, 0, 1, 5'b11100);
    // short bounce ignored
    add(0, 0, 5, 5'b11100);  add(1, 0, 20, 5'b11100);
    // long press: low 11 cycles after press, then 10 + 16/20/24 on release
    add(0, 0, 10, 5'b11100); add(0, 0, 1, 5'b00010); add(0, 0, 19, 5'b00010);
    add(1, 0, 25, 5'b00010); add(1, 0, 1, 5'b10010); add(1, 0, 3, 5'b10010);
    add(1, 0, 1, 5'b11010);  add(1, 0, 3, 5'b11010); add(1, 0, 1, 5'b11100);
    // software handshake
    add(1, 1, 1, 5'b00010);  add(1, 1, 15, 5'b00010); add(1, 1, 1, 5'b10010);
    add(1, 1, 4, 5'b11010);  add(1, 1, 4, 5'b11100);  add(1, 1, 1, 5'b11101);
    add(1, 1, 5, 5'b11101);  add(1, 0, 1, 5'b11100);  add(1, 1, 1, 5'b00010);
    // press lands in REL1, req dropped mid-sequence -> no ack
    add(1, 1, 11, 5'b00010); add(0, 0, 5, 5'b10010);  add(0, 0, 4, 5'b11010);
    add(0, 0, 1, 5'b11010);  add(0, 0, 1, 5'b00010);  add(1, 0, 25, 5'b00010);
    add(1, 0, 1, 5'b10010);  add(1, 0, 8, 5'b11100);  add(1, 0, 2, 5'b11100);
    // get ack high before the async reset
    add(1, 1, 1, 5'b00010);  add(1, 1, 24, 5'b11100); add(1, 1, 1, 5'b11101);
    n_split = vq.size();
    // after async reset: req held outside RUN is only accepted once RUN is reached
    add(1, 1, 15, 5'b00010); add(1, 1, 1, 5'b10010);  add(1, 1, 8, 5'b11100);
    add(1, 1, 1, 5'b00010);  add(1, 0, 1, 5'b00010);

    rst_n        = 1'b0;
    btn_rst_n_i  = 1'b1;
    sw_rst_req_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("reset_state", 5'b00010);
    rst_n = 1'b1;

    for (int i = 0; i < n_split; i++) apply(i);

    #3 rst_n = 1'b0;
    #1 check("async_reset_immediate", 5'b00010);
    @(negedge clk_i);
    check("async_reset_held", 5'b00010);
    rst_n = 1'b1;

    for (int i = n_split; i < vq.size(); i++) apply(i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
